// File: rtl/audio_pkg.sv
// Shared constants and helpers for the note player: clock defaults, I2S counter
// layout and the square-wave sample formatter.
package audio_pkg;

    localparam int unsigned CLK_FREQ   = 100_000_000;
    localparam int unsigned SIL_THRESH = 20_000;
    localparam logic [15:0] AMP_STEP   = 16'h0800;
    localparam int          ACC_W      = 27;

    localparam int CNT_W     = 9;
    localparam int MCLK_BIT  = 1;
    localparam int SCK_BIT   = 3;
    localparam int SLOT_LSB  = 4;
    localparam int SLOT_MSB  = 7;
    localparam int LRCK_BIT  = 8;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    function automatic int unsigned half_clk(input int unsigned freq);
        return freq / 2;
    endfunction

    localparam int unsigned HALF_CLK = half_clk(CLK_FREQ);

    // Square bit selects +amplitude or its two's complement; muted channels emit zero.
    function automatic logic [15:0] channel_sample(input logic sq, input logic [2:0] vol,
                                                   input logic mute);
        logic [15:0] amp;
        amp = 16'(vol) * AMP_STEP;
        if (mute || (vol == 3'd0))
            return 16'h0000;
        return sq ? amp : (~amp + 16'd1);
    endfunction

endpackage

// File: rtl/tone_square_gen.sv
// One channel's phase accumulator: toggles a square bit every half period of
// the requested tone, held at zero while silent or paused.
module tone_square_gen
    import audio_pkg::*;
#(
    parameter int unsigned HALF_CNT  = HALF_CLK,
    parameter int unsigned SIL_LIMIT = audio_pkg::SIL_THRESH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play,
    input  logic [31:0] tone,
    output logic        sq,
    output logic        silent
);

    localparam logic [32:0] HALF_W = 33'(HALF_CNT);

    logic [ACC_W-1:0] acc;
    logic [32:0]      sum;

    assign silent = (tone == 32'd0) || (tone >= 32'(SIL_LIMIT));
    assign sum    = {{(33-ACC_W){1'b0}}, acc} + {1'b0, tone};

    // Phase is never cleared on a tone change, only on silence or pause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            sq  <= 1'b0;
        end else if (silent || !play) begin
            acc <= '0;
            sq  <= 1'b0;
        end else if (sum >= HALF_W) begin
            acc <= ACC_W'(sum - HALF_W);
            sq  <= ~sq;
        end else begin
            acc <= ACC_W'(sum);
        end
    end

endmodule

// File: rtl/note_player_i2s.sv
// Beat sequencer plus two-channel square-wave synthesizer streamed out over I2S
// as 16-bit MSB-first words with the standard one-bit delay.
module note_player_i2s
    import audio_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = audio_pkg::CLK_FREQ,
    parameter int unsigned BEAT_FREQ  = 8,
    parameter int unsigned SONG_LEN   = 128,
    parameter int unsigned SIL_THRESH = audio_pkg::SIL_THRESH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play,
    input  logic [2:0]  vol,
    input  logic [31:0] tone_l,
    input  logic [31:0] tone_r,
    output logic [11:0] beat_num,
    output logic        audio_mclk,
    output logic        audio_lrck,
    output logic        audio_sck,
    output logic        audio_sdin
);

    localparam int unsigned      BEAT_DIV  = CLK_FREQ / BEAT_FREQ;
    localparam logic [31:0]      DIV_LAST  = 32'(BEAT_DIV - 1);
    localparam logic [11:0]      BEAT_LAST = 12'(SONG_LEN - 1);
    localparam int unsigned      HALF_CNT  = half_clk(CLK_FREQ);
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;

    logic [31:0]      beat_div;
    logic             sq_l, sq_r, sil_l, sil_r;
    logic [15:0]      sample_l, sample_r;
    logic [15:0]      frame_l, frame_r;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       slot;
    logic [3:0]       bit_idx;
    chan_e            half;
    logic [15:0]      word_cur, word_prev;
    logic             next_bit;

    // Divider freezes while paused so resuming finishes the interrupted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_div <= '0;
            beat_num <= '0;
        end else if (play) begin
            if (beat_div == DIV_LAST) begin
                beat_div <= '0;
                beat_num <= (beat_num == BEAT_LAST) ? 12'd0 : beat_num + 12'd1;
            end else begin
                beat_div <= beat_div + 32'd1;
            end
        end
    end

    tone_square_gen #(
        .HALF_CNT  (HALF_CNT),
        .SIL_LIMIT (SIL_THRESH)
    ) u_tone_l (
        .clk    (clk),
        .rst_n  (rst_n),
        .play   (play),
        .tone   (tone_l),
        .sq     (sq_l),
        .silent (sil_l)
    );

    tone_square_gen #(
        .HALF_CNT  (HALF_CNT),
        .SIL_LIMIT (SIL_THRESH)
    ) u_tone_r (
        .clk    (clk),
        .rst_n  (rst_n),
        .play   (play),
        .tone   (tone_r),
        .sq     (sq_r),
        .silent (sil_r)
    );

    assign sample_l = channel_sample(sq_l, vol, sil_l || !play);
    assign sample_r = channel_sample(sq_r, vol, sil_r || !play);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            frame_l <= '0;
            frame_r <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (cnt == '0) begin
                frame_l <= sample_l;
                frame_r <= sample_r;
            end
        end
    end

    assign cnt_nxt    = cnt + CNT_ONE;
    assign audio_mclk = cnt[MCLK_BIT];
    assign audio_sck  = cnt[SCK_BIT];
    assign audio_lrck = cnt[LRCK_BIT];

    // The bit is chosen for the slot about to start, since sdin loads one clk early.
    always_comb begin
        slot      = cnt_nxt[SLOT_MSB:SLOT_LSB];
        half      = chan_e'(cnt_nxt[LRCK_BIT]);
        word_cur  = (half == CH_RIGHT) ? frame_r : frame_l;
        word_prev = (half == CH_RIGHT) ? frame_l : frame_r;
        bit_idx   = 4'(5'd16 - {1'b0, slot});
        next_bit  = 1'b0;
        if (slot == 4'd0)
            next_bit = word_prev[0];
        else
            next_bit = word_cur[bit_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            audio_sdin <= 1'b0;
        else if (cnt[SLOT_LSB-1:0] == '1)
            audio_sdin <= next_bit;
    end

endmodule

// File: tb/tb_note_player_i2s.sv
// Randomized scoreboard bench: a phase-sum reference model predicts each I2S
// frame and the beat index; a monitor deserializes audio_sdin and compares.
module tb_note_player_i2s;

    localparam int CLK_FREQ  = 1000;
    localparam int BEAT_FREQ = 100;
    localparam int SONG_LEN  = 128;
    localparam int SIL       = 400;
    localparam int HALF      = CLK_FREQ / 2;
    localparam int DIV       = CLK_FREQ / BEAT_FREQ;
    localparam int FRAME     = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        play = 1'b0;
    logic [2:0]  vol = 3'd0;
    logic [31:0] tone_l, tone_r;
    logic [11:0] beat_num;
    logic        audio_mclk, audio_lrck, audio_sck, audio_sdin;

    logic [31:0] scoreL [SONG_LEN];
    logic [31:0] scoreR [SONG_LEN];

    int tests = 0;
    int fails = 0;

    // Reference model state
    longint      cycles, played, sumL, sumR;
    int          mbeat;
    logic [31:0] mtl, mtr;
    logic [31:0] expQ [$];

    // Monitor state
    logic        prevSck, lastLr, started;
    int          slot;
    logic [31:0] sh, expFrame;

    always #5 clk = ~clk;

    assign tone_l = scoreL[beat_num[6:0]];
    assign tone_r = scoreR[beat_num[6:0]];

    note_player_i2s #(
        .CLK_FREQ   (CLK_FREQ),
        .BEAT_FREQ  (BEAT_FREQ),
        .SONG_LEN   (SONG_LEN),
        .SIL_THRESH (SIL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .play       (play),
        .vol        (vol),
        .tone_l     (tone_l),
        .tone_r     (tone_r),
        .beat_num   (beat_num),
        .audio_mclk (audio_mclk),
        .audio_lrck (audio_lrck),
        .audio_sck  (audio_sck),
        .audio_sdin (audio_sdin)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit isSilent(input logic [31:0] t);
        return (t == 0) || (t >= SIL);
    endfunction

    // Square bit = parity of completed half periods in the cumulative phase.
    function automatic logic [15:0] refSample(input longint s, input logic [31:0] t,
                                              input logic p, input logic [2:0] v);
        int amp;
        if (!p || isSilent(t) || v == 0)
            return 16'h0000;
        amp = int'(v) * 2048;
        if (((s / HALF) % 2) == 1)
            return 16'(amp);
        return 16'(65536 - amp);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cycles = 0;
                played = 0;
                sumL   = 0;
                sumR   = 0;
                mbeat  = 0;
                expQ.delete();
            end else begin
                mtl = scoreL[mbeat];
                mtr = scoreR[mbeat];
                if (cycles % FRAME == 0)
                    expQ.push_back({refSample(sumL, mtl, play, vol), refSample(sumR, mtr, play, vol)});
                sumL = (play && !isSilent(mtl)) ? sumL + longint'(mtl) : 0;
                sumR = (play && !isSilent(mtr)) ? sumR + longint'(mtr) : 0;
                if (play)
                    played++;
                mbeat  = int'((played / DIV) % SONG_LEN);
                cycles++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                prevSck = 1'b0;
                lastLr  = 1'b1;
                started = 1'b0;
                slot    = 0;
                sh      = '0;
            end else begin
                checkOutput("beat_num", {20'd0, beat_num}, 32'(mbeat));
                checkOutput("i2s_clocks", {29'd0, audio_lrck, audio_sck, audio_mclk},
                            {29'd0, cycles[8], cycles[3], cycles[1]});
                if (audio_sck && !prevSck) begin
                    if (audio_lrck != lastLr)
                        slot = 0;
                    else
                        slot++;
                    lastLr = audio_lrck;
                    sh = {sh[30:0], audio_sdin};
                    if (!audio_lrck && slot == 0 && started) begin
                        if (expQ.size() == 0) begin
                            checkOutput("frame_queue_empty", 32'd0, 32'd1);
                        end else begin
                            expFrame = expQ.pop_front();
                            checkOutput("i2s_frame", sh, expFrame);
                        end
                    end
                    if (!audio_lrck && slot == 1)
                        started = 1'b1;
                end
                prevSck = audio_sck;
            end
        end
    end

    task automatic runCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitBeat(input int target, input int budget);
        int waited;
        waited = 0;
        while (mbeat != target && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("wait_beat", 32'(mbeat), 32'(target));
    endtask

    task automatic applyStimulus(input logic [2:0] v, input logic p, input int n);
        vol  = v;
        play = p;
        runCycles(n);
    endtask

    initial begin
        int r;
        for (int i = 0; i < SONG_LEN; i++) begin
            r = $urandom_range(0, 9);
            scoreL[i] = (r < 2) ? 32'd0 : (r < 4) ? 32'($urandom_range(SIL, 1200))
                                                  : 32'($urandom_range(1, SIL - 1));
            r = $urandom_range(0, 9);
            scoreR[i] = (r < 2) ? 32'd0 : (r < 4) ? 32'($urandom_range(SIL, 1200))
                                                  : 32'($urandom_range(1, SIL - 1));
        end
        scoreL[0] = 32'd262;
        scoreR[0] = 32'd0;
        scoreL[3] = 32'(SIL);
        scoreL[4] = 32'(SIL - 1);
        scoreR[4] = 32'd1;

        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_hold", {beat_num, 16'd0, audio_mclk, audio_lrck, audio_sck, audio_sdin}, 32'd0);
        end
        rst_n = 1'b1;
        applyStimulus(3'd5, 1'b1, 2000);

        waitBeat(37, 2000);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", {beat_num, 16'd0, audio_mclk, audio_lrck, audio_sck, audio_sdin}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        waitBeat(5, 200);
        applyStimulus(3'd6, 1'b0, 1100);
        applyStimulus(3'd6, 1'b1, 600);

        repeat (10)
            applyStimulus(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                          $urandom_range(200, 1500));

        applyStimulus(3'd7, 1'b1, 1500);
        applyStimulus(3'd0, 1'b1, 700);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
